multi_chan_prescale_counter: RTL and testbench
==============================================

Name: multi_chan_prescale_counter

Overview:
- Bank of NCH independent up-counters with one increment-event input, steered to a single channel per cycle by Slt.
- Each channel has a run-time programmable prescaler: the visible count advances once per DIV qualifying events.
- Optional saturate mode and a per-channel terminal-count pulse.
- Sits in the datapath test/perf area as a generic event-statistics block, replacing fixed two-channel counters.

Parameters:
- WIDTH, 64, bit width of each visible counter.
- NCH, 4, number of channels (>=2).
- SEL_W, $clog2(NCH), width of the channel selects (derived; do not override).
- DIV_W, 8, width of each prescale divider register.
- DIV_RST, 1, reset value of every channel divider.
- SAT, 0, overflow mode: 0 = wrap to 0, 1 = saturate at all-ones.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high; clock Clk.
- En  input  1  event strobe; one event per cycle when high.
- Slt  input  SEL_W  channel receiving the event; values >= NCH are ignored.
- Clr  input  NCH  per-channel synchronous clear of the count and prescale state.
- Div_we  input  1  divider write strobe.
- Div_ch  input  SEL_W  channel whose divider is written; values >= NCH are ignored.
- Div_val  input  DIV_W  new divider value; 0 is treated as 1.
- Count  output  NCH*WIDTH  visible counts, channel c at bits [c*WIDTH +: WIDTH], registered.
- Tc  output  NCH  one-cycle terminal-count pulse per channel, registered.

Behaviour:
- Reset: Count = 0, prescale = 0, divider = DIV_RST for all channels, Tc = 0. Reset overrides every other input.
- Priority per channel c, highest first: Reset, Clr[c], divider write to c, event.
- Event: a cycle with En=1 and Slt=c (c<NCH) is a qualifying event for channel c. No other channel changes.
- Prescale: on a qualifying event, if prescale == eff_div-1, then prescale <- 0 and Count[c] increments; otherwise prescale <- prescale+1.
  - eff_div = max(divider,1).
  - Count is updated on the same edge as the event (1-cycle latency).
  - With divider=1, Count increments on every event.
- Divider write: at the edge, divider[Div_ch] <- Div_val and that channel's prescale <- 0. A qualifying event to the same channel in the same cycle is dropped (neither prescale nor Count changes). Other channels still count normally.
- Clr[c]: Count[c] <- 0 and prescale[c] <- 0. The divider is kept. A simultaneous event or divider write to c is ignored.
- Overflow, SAT=0: all-ones + 1 -> 0, and Tc[c]=1 in the following cycle.
- Overflow, SAT=1: Count holds at all-ones. Tc[c] pulses only on the increment that reaches all-ones; further events give no pulse.
- Tc is high for exactly one cycle per terminal event and is 0 whenever Reset is high.
- Arithmetic is unsigned, and the prescale counter is DIV_W bits wide.

Decomposition:
- No shared package needed. A local function computes eff_div.
- One natural sub-module, prescale_counter_chan (single channel: prescale, counter, Tc, sat/wrap). The top instantiates NCH copies via generate and decodes Slt and Div_ch into per-channel strobes.

Test Plan:
- Reset, then 4 events on Slt=1, divider 1 -> Count[1]=4 on the edge after the 4th event; all other channels 0; Tc=0.
- Write Div_ch=2, Div_val=4, then 9 events on channel 2 -> Count[2] increments after events 4 and 8, ending at 2 with prescale at 1. Repeat with Div_val=0 -> behaves as divider 1.
- WIDTH=8, SAT=0: channel 0 preset to 255 via 255 events, one more event -> Count[0]=0, Tc[0] high for exactly 1 cycle. Same with SAT=1 -> Count[0] stays 255; Tc pulses once at the 254->255 step and never again.
- Same cycle: Div_we to channel 3 plus an event to 3, and an event to 0 on the next cycle -> channel 3 unchanged with prescale 0; channel 0 counts. Then Clr[3] plus an event to 3 -> Count[3]=0.
- Slt=NCH (with non-power-of-2 NCH=3) and En=1 -> no channel changes. Reset asserted mid-run with En=1 -> all Count=0, dividers=DIV_RST, Tc=0 on the next cycle.

Source files
------------

// File: rtl/multi_chan_prescale_counter_chan.sv
// ============================================================================
// Module  : prescale_counter_chan
// Brief   : One counter channel: prescaler, visible count, wrap/saturate, Tc.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prescale_counter_chan #(
  parameter int WIDTH   = 64,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 1,
  parameter int SAT     = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_clr,
  input  logic             i_ev,
  input  logic             i_div_we,
  input  logic [DIV_W-1:0] i_div_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  // A programmed divider of zero behaves exactly like a divider of one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic [DIV_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div;
  logic             r_tc;

  logic [DIV_W-1:0] w_pre_last;
  logic             w_at_max;
  logic             w_to_max;

  assign w_pre_last = eff_div(r_div) - DIV_W'(1);
  assign w_at_max   = (r_count == {WIDTH{1'b1}});
  assign w_to_max   = (r_count == {{(WIDTH-1){1'b1}}, 1'b0});

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
      r_pre   <= '0;
      r_div   <= DIV_W'(DIV_RST);
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (i_clr) begin
        r_count <= '0;
        r_pre   <= '0;
      end else if (i_div_we) begin
        r_div <= i_div_val;
        r_pre <= '0;
      end else if (i_ev) begin
        if (r_pre == w_pre_last) begin
          r_pre <= '0;
          if (SAT != 0) begin
            // Saturating: hold at all-ones, pulse only on the step onto it.
            if (!w_at_max) begin
              r_count <= r_count + WIDTH'(1);
              r_tc    <= w_to_max;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
            r_tc    <= w_at_max;
          end
        end else begin
          r_pre <= r_pre + DIV_W'(1);
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;

endmodule

`default_nettype wire

// File: rtl/multi_chan_prescale_counter.sv
// ============================================================================
// Module  : multi_chan_prescale_counter
// Brief   : Bank of NCH prescaled event counters sharing one steered strobe.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_chan_prescale_counter #(
  parameter int WIDTH   = 64,
  parameter int NCH     = 4,
  parameter int SEL_W   = $clog2(NCH),
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 1,
  parameter int SAT     = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [SEL_W-1:0]     Slt,
  input  logic [NCH-1:0]       Clr,
  input  logic                 Div_we,
  input  logic [SEL_W-1:0]     Div_ch,
  input  logic [DIV_W-1:0]     Div_val,
  output logic [NCH*WIDTH-1:0] Count,
  output logic [NCH-1:0]       Tc
);

  // Selects >= NCH match no channel, so out-of-range events and writes vanish.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic w_ev;
    logic w_we;

    assign w_ev = En     && (Slt    == SEL_W'(gi));
    assign w_we = Div_we && (Div_ch == SEL_W'(gi));

    prescale_counter_chan #(
      .WIDTH   (WIDTH),
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST),
      .SAT     (SAT)
    ) u_chan (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_clr     (Clr[gi]),
      .i_ev      (w_ev),
      .i_div_we  (w_we),
      .i_div_val (Div_val),
      .o_count   (Count[gi*WIDTH +: WIDTH]),
      .o_tc      (Tc[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_chan_prescale_counter.sv
// ============================================================================
// Module  : tb_multi_chan_prescale_counter
// Brief   : Randomised check of three counter banks against a rule-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_chan_prescale_counter;

  // Bank 0: W8/N3 wrap, bank 1: W8/N3 saturate, bank 2: W64/N4 wrap.
  localparam int NB = 3;
  localparam int BW [NB] = '{8, 8, 64};
  localparam int BN [NB] = '{3, 3, 4};
  localparam int BS [NB] = '{0, 1, 0};

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       En = 1'b0;
  logic [1:0] Slt = '0;
  logic [3:0] Clr = '0;
  logic       Div_we = 1'b0;
  logic [1:0] Div_ch = '0;
  logic [7:0] Div_val = '0;

  logic [23:0]  Count0, Count1;
  logic [255:0] Count2;
  logic [2:0]   Tc0, Tc1;
  logic [3:0]   Tc2;

  always #5 Clk = ~Clk;

  multi_chan_prescale_counter #(.WIDTH(8), .NCH(3), .SAT(0)) u_d0 (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr[2:0]), .Div_we(Div_we),
    .Div_ch(Div_ch), .Div_val(Div_val), .Count(Count0), .Tc(Tc0));
  multi_chan_prescale_counter #(.WIDTH(8), .NCH(3), .SAT(1)) u_d1 (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr[2:0]), .Div_we(Div_we),
    .Div_ch(Div_ch), .Div_val(Div_val), .Count(Count1), .Tc(Tc1));
  multi_chan_prescale_counter u_d2 (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr), .Div_we(Div_we),
    .Div_ch(Div_ch), .Div_val(Div_val), .Count(Count2), .Tc(Tc2));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_cnt(input int d, input int c);
    case (d)
      0:       return 64'(Count0[c*8 +: 8]);
      1:       return 64'(Count1[c*8 +: 8]);
      default: return Count2[c*64 +: 64];
    endcase
  endfunction

  function automatic logic dut_tc(input int d, input int c);
    case (d)
      0:       return Tc0[c];
      1:       return Tc1[c];
      default: return Tc2[c];
    endcase
  endfunction

  // Reference state: visible count, events seen since last increment, divider.
  longint unsigned m_cnt [NB][4];
  int              m_pre [NB][4];
  int              m_div [NB][4];
  bit              m_tc  [NB][4];
  bit              started = 1'b0;

  always @(posedge Clk) begin
    for (int d = 0; d < NB; d++) begin
      longint unsigned maxv;
      maxv = (BW[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << BW[d]) - 64'd1);
      for (int c = 0; c < BN[d]; c++) begin
        m_tc[d][c] = 1'b0;
        if (Reset) begin
          m_cnt[d][c] = 0;
          m_pre[d][c] = 0;
          m_div[d][c] = 1;
        end else if (Clr[c]) begin
          m_cnt[d][c] = 0;
          m_pre[d][c] = 0;
        end else if (Div_we && int'(Div_ch) == c) begin
          m_div[d][c] = int'(Div_val);
          m_pre[d][c] = 0;
        end else if (En && int'(Slt) == c) begin
          int eff;
          eff = (m_div[d][c] == 0) ? 1 : m_div[d][c];
          m_pre[d][c] = m_pre[d][c] + 1;
          if (m_pre[d][c] == eff) begin
            m_pre[d][c] = 0;
            if (m_cnt[d][c] == maxv) begin
              if (BS[d] == 0) begin
                m_cnt[d][c] = 0;
                m_tc[d][c]  = 1'b1;
              end
            end else begin
              m_cnt[d][c] = m_cnt[d][c] + 1;
              if (BS[d] != 0 && m_cnt[d][c] == maxv) m_tc[d][c] = 1'b1;
            end
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge Clk) begin
    if (started) begin
      for (int d = 0; d < NB; d++) begin
        for (int c = 0; c < BN[d]; c++) begin
          check($sformatf("model count b%0d c%0d", d, c), dut_cnt(d, c), m_cnt[d][c]);
          check($sformatf("model tc b%0d c%0d", d, c), 64'(dut_tc(d, c)), 64'(m_tc[d][c]));
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic en, input logic [1:0] slt,
                       input logic [3:0] clr, input logic we, input logic [1:0] ch,
                       input logic [7:0] val);
    @(negedge Clk);
    Reset = rst; En = en; Slt = slt; Clr = clr; Div_we = we; Div_ch = ch; Div_val = val;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic ev(input logic [1:0] slt, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, slt, 4'h0, 1'b0, 2'd0, 8'd0);
  endtask

  initial begin
    // Reset with a live strobe: reset must win.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'(i), 4'h0, 1'b0, 2'd0, 8'd0);
    idle();
    check("reset count b2 c1", dut_cnt(2, 1), 64'd0);
    check("reset tc b0", 64'(Tc0), 64'd0);

    ev(2'd1, 4); idle();
    check("div1 count b0 c1", dut_cnt(0, 1), 64'd4);
    check("div1 other b0 c0", dut_cnt(0, 0), 64'd0);

    drive(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 8'd4);
    ev(2'd2, 9); idle();
    check("div4 9ev b0 c2", dut_cnt(0, 2), 64'd2);
    ev(2'd2, 3); idle();
    check("div4 12ev b2 c2", dut_cnt(2, 2), 64'd3);
    drive(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 8'd0);
    ev(2'd2, 2); idle();
    check("div0 as 1 b0 c2", dut_cnt(0, 2), 64'd5);

    drive(1'b0, 1'b0, 2'd0, 4'h1, 1'b0, 2'd0, 8'd0);
    ev(2'd0, 255); idle();
    check("sat reach tc b1 c0", 64'(Tc1[0]), 64'd1);
    check("wrap no tc at 255 b0", 64'(Tc0[0]), 64'd0);
    ev(2'd0, 1); idle();
    check("wrap count b0 c0", dut_cnt(0, 0), 64'd0);
    check("wrap tc b0 c0", 64'(Tc0[0]), 64'd1);
    check("sat hold b1 c0", dut_cnt(1, 0), 64'd255);
    check("sat no 2nd tc b1", 64'(Tc1[0]), 64'd0);
    idle();
    check("wrap tc one cycle", 64'(Tc0[0]), 64'd0);

    // Divider write beats a same-cycle event to the same channel.
    drive(1'b0, 1'b1, 2'd2, 4'h0, 1'b1, 2'd2, 8'd1);
    ev(2'd0, 1); idle();
    check("we drops ev b0 c2", dut_cnt(0, 2), 64'd5);
    check("other chan counts b0 c0", dut_cnt(0, 0), 64'd1);
    drive(1'b0, 1'b1, 2'd2, 4'h4, 1'b0, 2'd0, 8'd0);
    idle();
    check("clr beats ev b0 c2", dut_cnt(0, 2), 64'd0);

    ev(2'd3, 3); idle();
    check("slt oob ignored b0 c1", dut_cnt(0, 1), 64'd4);
    check("slt 3 counts b2 c3", dut_cnt(2, 3), 64'd3);

    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            (($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : 4'h0),
            ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
    end

    drive(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 8'd5);
    drive(1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 2'd0, 8'd0);
    idle();
    check("midrun reset b0 c2", dut_cnt(0, 2), 64'd0);
    check("midrun reset tc b2", 64'(Tc2), 64'd0);
    ev(2'd2, 1); idle();
    check("divider back to 1", dut_cnt(0, 2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
